// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with load FIFO and busy scoreboard
// Optional direct load-to-port path when idle: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_wb_en,
  input  logic [AW-1:0]                alu_wb_dest,
  input  logic [DW-1:0]                alu_wb_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_dest,
  input  logic [DW-1:0]                mem_data,
  input  logic                         ld_issue,
  input  logic [AW-1:0]                ld_dest,
  input  logic [AW-1:0]                src1,
  input  logic [AW-1:0]                src2,
  input  logic [AW-1:0]                dst_chk,
  output logic                         hz_src1,
  output logic                         hz_src2,
  output logic                         hz_dst,
  output logic [(1<<AW)-1:0]           busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         wr_en,
  output logic [AW-1:0]                wr_dest,
  output logic [DW-1:0]                wr_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 1 << AW;

  logic [AW-1:0] r_fifo_dest [DEPTH];
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [NR-1:0] r_busy;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_dest;
  logic [DW-1:0] r_wr_data;

  logic          w_accept, w_empty, w_pop, w_bypass, w_push;
  logic [NR-1:0] w_set, w_clr;

  assign mem_ready = (r_count < CW'(DEPTH));
  assign w_accept  = mem_valid & mem_ready;
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~alu_wb_en & ~w_empty;
`ifdef REGFILE_WB_BYPASS_EN
  assign w_bypass  = ~alu_wb_en & w_empty & w_accept;
`else
  assign w_bypass  = 1'b0;
`endif
  assign w_push    = w_accept & ~w_bypass;

  // Clear only on load-path writes; a same-cycle reissue re-sets the bit.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ld_issue) w_set[ld_dest] = 1'b1;
    if (w_pop) w_clr[r_fifo_dest[r_rptr]] = 1'b1;
    else if (w_bypass) w_clr[mem_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dest[r_wptr] <= mem_dest;
      r_fifo_data[r_wptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_dest <= '0;
      r_wr_data <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
    end else begin
      if (alu_wb_en) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= alu_wb_dest;
        r_wr_data <= alu_wb_data;
      end else if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= r_fifo_dest[r_rptr];
        r_wr_data <= r_fifo_data[r_rptr];
      end else if (w_bypass) begin
        r_wr_en   <= 1'b1;
        r_wr_dest <= mem_dest;
        r_wr_data <= mem_data;
      end else begin
        r_wr_en   <= 1'b0;
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_busy  <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign wr_en      = r_wr_en;
  assign wr_dest    = r_wr_dest;
  assign wr_data    = r_wr_data;
  assign hz_src1    = r_busy[src1];
  assign hz_src2    = r_busy[src2];
  assign hz_dst     = r_busy[dst_chk];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_en;
  logic [3:0]  alu_wb_dest;
  logic [31:0] alu_wb_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_dest;
  logic [31:0] mem_data;
  logic        ld_issue;
  logic [3:0]  ld_dest;
  logic [3:0]  src1, src2, dst_chk;
  logic        hz_src1, hz_src2, hz_dst;
  logic [15:0] busy;
  logic [1:0]  fifo_count;
  logic        wr_en;
  logic [3:0]  wr_dest;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_en(alu_wb_en), .alu_wb_dest(alu_wb_dest), .alu_wb_data(alu_wb_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .src1(src1), .src2(src2), .dst_chk(dst_chk),
    .hz_src1(hz_src1), .hz_src2(hz_src2), .hz_dst(hz_dst),
    .busy(busy), .fifo_count(fifo_count),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data)
  );

  // Reference model: pending loads as a queue, scoreboard as a bit vector.
  typedef struct packed { logic [3:0] d; logic [31:0] v; } ent_t;
  ent_t        q[$];
  logic [15:0] m_busy;
  logic        m_wr_en;
  logic [3:0]  m_wr_dest;
  logic [31:0] m_wr_data;
  bit          last_accept;
  logic [31:0] wrap_log[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic compare_all();
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_dest", wr_dest, m_wr_dest);
    chk("wr_data", wr_data, m_wr_data);
    chk("busy", busy, m_busy);
    chk("fifo_count", fifo_count, q.size());
    chk("mem_ready", mem_ready, q.size() < DEPTH);
    chk("hz_src1", hz_src1, m_busy[src1]);
    chk("hz_src2", hz_src2, m_busy[src2]);
    chk("hz_dst", hz_dst, m_busy[dst_chk]);
    if (wr_en === 1'b1 && wr_data[31:16] == 16'hA5A5) wrap_log.push_back(wr_data);
  endtask

  task automatic model_next();
    bit acc, byp;
    ent_t e;
    if (rst) begin
      q.delete(); m_busy = '0; m_wr_en = 0; m_wr_dest = '0; m_wr_data = '0; last_accept = 0;
      return;
    end
    acc = mem_valid && (q.size() < DEPTH);
    byp = 0;
    if (alu_wb_en) begin
      m_wr_en = 1; m_wr_dest = alu_wb_dest; m_wr_data = alu_wb_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_wr_en = 1; m_wr_dest = e.d; m_wr_data = e.v; m_busy[e.d] = 1'b0;
    end else begin
`ifdef REGFILE_WB_BYPASS_EN
      if (acc) begin
        m_wr_en = 1; m_wr_dest = mem_dest; m_wr_data = mem_data; m_busy[mem_dest] = 1'b0;
        byp = 1;
      end else m_wr_en = 0;
`else
      m_wr_en = 0;
`endif
    end
    if (acc && !byp) q.push_back({mem_dest, mem_data});
    if (ld_issue) m_busy[ld_dest] = 1'b1;
    last_accept = acc;
  endtask

  // Inputs change at negedge; outputs are compared 1ns later, then the model advances.
  task automatic step();
    #1;
    compare_all();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_wb_en = 0; mem_valid = 0; ld_issue = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 16'h0);
    chk("rst_fifo_count", fifo_count, 2'd0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    model_next();
    idle();
    step();
    rst = 0;
  endtask

  logic [3:0]  c_dest[3];
  logic [31:0] c_data[3];
  int idx;

  initial begin
    rst = 0; idle();
    alu_wb_dest = 0; alu_wb_data = 0; mem_dest = 0; mem_data = 0;
    ld_dest = 0; src1 = 0; src2 = 0; dst_chk = 0;
    m_busy = '0; m_wr_en = 0; m_wr_dest = '0; m_wr_data = '0; last_accept = 0;
    @(negedge clk);
    do_reset();
    step();

    // ALU path latency
    alu_wb_en = 1; alu_wb_dest = 3; alu_wb_data = 32'hDEADBEEF;
    step(); idle();
    chk("alu_lit_en", wr_en, 1'b1);
    chk("alu_lit_dest", wr_dest, 4'd3);
    chk("alu_lit_data", wr_data, 32'hDEADBEEF);
    step();

    // Contention: ALU holds the port while three returns arrive back-to-back
    c_dest[0] = 5; c_data[0] = 32'h55;
    c_dest[1] = 6; c_data[1] = 32'h66;
    c_dest[2] = 7; c_data[2] = 32'h77;
    idx = 0;
    alu_wb_en = 1; alu_wb_dest = 1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      alu_wb_data = 32'h100 + cyc;
      mem_valid = (idx < 3);
      if (idx < 3) begin mem_dest = c_dest[idx]; mem_data = c_data[idx]; end
      step();
      if (last_accept) idx++;
      if (cyc == 1) chk("cont_ready_low", mem_ready, 1'b0);
    end
    chk("cont_accepted", idx, 2);
    alu_wb_en = 0;
    step();
    chk("cont_w5_dest", wr_dest, 4'd5);
    chk("cont_w5_data", wr_data, 32'h55);
    step();
    if (last_accept) idx++;
    mem_valid = 0;
    chk("cont_w6_dest", wr_dest, 4'd6);
    chk("cont_w6_data", wr_data, 32'h66);
    chk("cont_r7_acc", idx, 3);
    step();
    chk("cont_w7_dest", wr_dest, 4'd7);
    chk("cont_w7_data", wr_data, 32'h77);
    step(); step();

    // Scoreboard set/clear and same-cycle reissue
    ld_issue = 1; ld_dest = 8; src1 = 8;
    step(); ld_issue = 0;
    chk("sb_hz_set", hz_src1, 1'b1);
    step();
    chk("sb_hz_hold", hz_src1, 1'b1);
    mem_valid = 1; mem_dest = 8; mem_data = 32'h88;
`ifdef REGFILE_WB_BYPASS_EN
    ld_issue = 1; ld_dest = 8;
    step(); mem_valid = 0; ld_issue = 0;
`else
    step(); mem_valid = 0;
    chk("sb_hz_queued", hz_src1, 1'b1);
    ld_issue = 1; ld_dest = 8;
    step(); ld_issue = 0;
`endif
    chk("sb_wr_dest", wr_dest, 4'd8);
    chk("sb_wr_en", wr_en, 1'b1);
    chk("sb_reissue_busy", busy[8], 1'b1);
    mem_valid = 1; mem_data = 32'h89;
    step(); mem_valid = 0;
    step(); step();
    chk("sb_hz_clear", hz_src1, 1'b0);

    // Idle-port load return: bypass vs queued latency
    mem_valid = 1; mem_dest = 2; mem_data = 32'h22;
    step(); mem_valid = 0;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_wr_en", wr_en, 1'b1);
    chk("byp_count", fifo_count, 2'd0);
    chk("byp_data", wr_data, 32'h22);
`else
    chk("nobyp_wr_en", wr_en, 1'b0);
    chk("nobyp_count", fifo_count, 2'd1);
    step();
    chk("nobyp_wr_en2", wr_en, 1'b1);
    chk("nobyp_data", wr_data, 32'h22);
`endif
    step(); step();

    // Wrap-around: ten returns, ALU busy every other cycle
    wrap_log.delete();
    idx = 0;
    alu_wb_dest = 1; alu_wb_data = 32'h1111;
    for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
      alu_wb_en = cyc[0];
      mem_valid = 1; mem_dest = 4'(2 + idx); mem_data = 32'hA5A5_0000 + idx;
      step();
      if (last_accept) idx++;
    end
    idle();
    chk("wrap_accepted", idx, 10);
    for (int k = 0; k < 8; k++) step();
    chk("wrap_count", wrap_log.size(), 10);
    for (int k = 0; k < 10 && k < wrap_log.size(); k++)
      chk("wrap_order", wrap_log[k], 32'hA5A5_0000 + k);

    // Asynchronous reset with two entries pending and r8 busy
    ld_issue = 1; ld_dest = 8;
    step(); ld_issue = 0;
    alu_wb_en = 1; alu_wb_dest = 1; alu_wb_data = 32'h4;
    mem_valid = 1; mem_dest = 9; mem_data = 32'h99;
    step();
    mem_dest = 10; mem_data = 32'hAA;
    step(); mem_valid = 0;
    chk("pre_rst_count", fifo_count, 2'd2);
    chk("pre_rst_busy", busy, 16'h0100);
    #2;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("post_rst_no_write", wr_en, 1'b0);

    // Randomized traffic with a holding load source
    for (int n = 0; n < 1500; n++) begin
      alu_wb_en = ($urandom_range(0, 2) == 0);
      alu_wb_dest = 4'($urandom); alu_wb_data = $urandom;
      if (!mem_valid || last_accept) begin
        mem_valid = ($urandom_range(0, 1) == 1);
        mem_dest = 4'($urandom); mem_data = $urandom;
      end
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_dest = 4'($urandom);
      src1 = 4'($urandom); src2 = 4'($urandom); dst_chk = 4'($urandom);
      step();
    end
    idle();
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and load scoreboard for the 16x32 register file. It merges two writeback sources onto the register file's single write port (Dest_wb/Result_wb/writeBackEn): the pipeline ALU writeback, which is never stalled, and SRAM load returns, which use a valid/ready handshake through a small FIFO. It tracks registers with outstanding loads and drives hazard flags to the decode stage. It sits between the WB stage and SRAM controller on one side and the register file on the other.

## Interface
- DEPTH, 2, load-return FIFO entries (power of two, >=2)
- DW, 32, data width
- AW, 4, register index width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_wb_en  in  1  ALU writeback request; always accepted
- alu_wb_dest  in  AW  ALU destination register
- alu_wb_data  in  DW  ALU result
- mem_valid  in  1  load return valid
- mem_ready  out  1  load return accepted when high together with mem_valid
- mem_dest  in  AW  load destination register
- mem_data  in  DW  load data
- ld_issue  in  1  load issued in MEM stage; marks ld_dest busy
- ld_dest  in  AW  destination of issued load
- src1, src2, dst_chk  in  AW  decode-stage register indices to check
- hz_src1, hz_src2, hz_dst  out  1  busy[src1], busy[src2], busy[dst_chk] (combinational)
- busy  out  2**AW  scoreboard vector
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy
- wr_en, wr_dest, wr_data  out  1/AW/DW  registered write port to the register file

## Operation
- Reset: wr_en=0, wr_dest=0, wr_data=0, busy=0, fifo_count=0, FIFO pointers=0, mem_ready=1. Pending FIFO entries are discarded.
- mem_ready = (fifo_count < DEPTH). It depends only on registered count and never on mem_valid.
- Each posedge, the port source is selected by strict priority:
  1. alu_wb_en=1: ALU source.
  2. Otherwise, FIFO not empty: pop the FIFO head.
  3. Otherwise, bypass case (see Configuration).
  4. Otherwise: wr_en<=0. wr_dest and wr_data hold their previous values.
- An accepted load return is pushed to the FIFO unless it was bypassed. Simultaneous push and pop leaves the count unchanged. A push when full cannot occur, because mem_ready=0.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH.
- Scoreboard:
  - ld_issue sets busy[ld_dest].
  - busy[d] clears on the posedge at which a load-path write to d is registered onto the port.
  - If set and clear hit the same register in the same cycle, the set wins.
  - ALU writes never touch busy.
- The upstream pipeline must stall on hz_dst before issuing an ALU write to a busy register. The arbiter does not reorder ALU writes against pending loads.

## Timing
- ALU write: request in cycle N -> wr_en=1 in cycle N+1.
- Load return through the FIFO: accepted in cycle N -> wr_en=1 in cycle N+2 at the earliest. It is delayed one extra cycle for each cycle alu_wb_en is high.
- The register file latches the port on the falling edge of the cycle wr_en is high. The hazard drops in that same cycle, so the data is valid before the next posedge.
- Sustained ALU traffic starves the FIFO indefinitely. This is by design; the pipeline inserts bubbles on load-use hazards.
- rst mid-operation clears all state immediately, regardless of clk.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - When alu_wb_en=0, the FIFO is empty, and a load return is accepted, it is written directly (wr_en=1 in N+1) and is not enqueued.
  - fifo_count stays 0.
- Undefined: every accepted return goes through the FIFO, giving the N+2 minimum latency.

## Test plan
- Reset: assert rst while FIFO holds 2 entries and busy=16'h0100 -> immediately wr_en=0, busy=0, fifo_count=0, mem_ready=1; no stale writes after release.
- ALU path: alu_wb_en=1, dest=3, data=32'hDEADBEEF in cycle N -> cycle N+1 wr_en=1, wr_dest=3, wr_data=32'hDEADBEEF.
- Contention: ALU writes r1 for 5 cycles while mem returns r5=32'h55, r6=32'h66, r7=32'h77 back-to-back -> only r5 and r6 are accepted and mem_ready=0; after the ALU stops, r5 then r6 are written in order, r7 is accepted, and its write follows.
- Scoreboard: ld_issue with ld_dest=8, src1=8 -> hz_src1=1 from the next cycle until the cycle wr_dest=8 comes from the load path. A new ld_issue to r8 in that same cycle keeps busy[8]=1.
- Bypass: idle port, mem_valid with r2=32'h22 in cycle N -> with the macro, wr_en=1 in N+1 and fifo_count stays 0; without it, fifo_count=1 in N+1 and wr_en=1 in N+2.
- Wrap-around: 10 load returns with the ALU idle every other cycle -> all 10 are written in issue order with correct data; fifo_count never exceeds DEPTH.
